// File: rtl/control_sequencer_if.sv
// control_sequencer_if: the instruction, branch-condition and stop inputs of
// the control unit, bundled with every datapath control strobe it drives.
//   master modport : the control sequencer (drives strobes, ALUop, Run)
//   slave modport  : the datapath side (drives IR, CON_FF, Stop)
// Parameter ALUW sets the width of the ALUop select.
interface control_sequencer_if #(
  parameter int ALUW = 4
);
  logic [31:0]     IR;
  logic            CON_FF;
  logic            Stop;
  // bus-drive enables
  logic            PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Rout;
  // register load enables
  logic            MARin, Zin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, CONin;
  // register-field selects, PC increment, memory strobes
  logic            Gra, Grb, Grc;
  logic            IncPC, Read, Write;
  logic [ALUW-1:0] ALUop;
  logic            Run;

  modport master (
    input  IR, CON_FF, Stop,
    output PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Rout,
           MARin, Zin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, CONin,
           Gra, Grb, Grc, IncPC, Read, Write, ALUop, Run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Rout,
           MARin, Zin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, CONin,
           Gra, Grb, Grc, IncPC, Read, Write, ALUop, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit. Steps one T-state per
// clock: fetch (T0-T2), opcode latch on T2->T3, execute (T3-T7), back to T0.
// Ports:
//   Clock : system clock, rising edge
//   Clear : asynchronous active-high reset (state -> RST, strobes 0, Run=1)
//   bus   : control_sequencer_if.master (IR, CON_FF, Stop in; strobes,
//           ALUop, Run out)
// Optional feature: define CTRL_MULDIV_EN to execute mul (01111) and
// div (10000); otherwise those opcodes run as nop and HIin/LOin stay 0.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input logic                  Clock,
  input logic                  Clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
`ifdef CTRL_MULDIV_EN
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [ALUW-1:0] ALU_MUL = ALUW'(4);
  localparam logic [ALUW-1:0] ALU_DIV = ALUW'(5);
`endif

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

  state_t         state, next;
  logic [OPW-1:0] op_q;
  logic           is_r, is_i, is_ld, is_st, is_br, is_jr, is_halt, is_md;
  logic           done;
  logic [ALUW-1:0] alu_op;

  // Only the opcode field of IR matters to the control unit.
  logic unused_ir;
  assign unused_ir = ^bus.IR[31-OPW:0];

  // ---------------------------------------------------------------- state
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= S_RST;
    else       state <= next;
  end

  // Opcode is sampled on the T2->T3 edge and held through execute.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)              op_q <= '0;
    else if (state == S_T2) op_q <= bus.IR[31 -: OPW];
  end

  // ---------------------------------------------------------------- decode
  always_comb begin
    is_r    = (op_q == OP_ADD)  || (op_q == OP_SUB) ||
              (op_q == OP_AND)  || (op_q == OP_OR);
    is_i    = (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
    is_ld   = (op_q == OP_LD);
    is_st   = (op_q == OP_ST);
    is_br   = (op_q == OP_BR);
    is_jr   = (op_q == OP_JR);
    is_halt = (op_q == OP_HALT);
`ifdef CTRL_MULDIV_EN
    is_md   = (op_q == OP_MUL)  || (op_q == OP_DIV);
`else
    is_md   = 1'b0;
`endif
  end

  // ALU function for the execute step that computes the result.
  always_comb begin
    alu_op = ALU_ADD;
    if      ((op_q == OP_SUB))                      alu_op = ALU_SUB;
    else if ((op_q == OP_AND) || (op_q == OP_ANDI)) alu_op = ALU_AND;
    else if ((op_q == OP_OR)  || (op_q == OP_ORI))  alu_op = ALU_OR;
`ifdef CTRL_MULDIV_EN
    else if (op_q == OP_MUL)                        alu_op = ALU_MUL;
    else if (op_q == OP_DIV)                        alu_op = ALU_DIV;
`endif
  end

  // ---------------------------------------------------------------- next state
  // 'done' marks every edge that would return to T0; Stop turns that edge
  // into HALT, so an instruction in flight always finishes first.
  always_comb begin
    next = state;
    done = 1'b0;
    unique case (state)
      S_RST:  done = 1'b1;
      S_T0:   next = S_T1;
      S_T1:   next = S_T2;
      S_T2:   next = S_T3;
      S_T3: begin
        if (is_halt)                                  next = S_HALT;
        else if (is_r || is_i || is_ld || is_st ||
                 is_br || is_md)                      next = S_T4;
        else                                          done = 1'b1;
      end
      S_T4:   next = S_T5;
      S_T5: begin
        if (is_r || is_i) done = 1'b1;
        else              next = S_T6;
      end
      S_T6: begin
        if (is_ld || is_st) next = S_T7;
        else                done = 1'b1;
      end
      S_T7:   done = 1'b1;
      S_HALT: next = S_HALT;
      default: next = S_RST;
    endcase
    if (done) next = bus.Stop ? S_HALT : S_T0;
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    bus.PCout    = 1'b0;  bus.Zhighout = 1'b0;  bus.Zlowout = 1'b0;
    bus.MDRout   = 1'b0;  bus.BAout    = 1'b0;  bus.Cout    = 1'b0;
    bus.Rout     = 1'b0;  bus.MARin    = 1'b0;  bus.Zin     = 1'b0;
    bus.PCin     = 1'b0;  bus.MDRin    = 1'b0;  bus.IRin    = 1'b0;
    bus.Yin      = 1'b0;  bus.Rin      = 1'b0;  bus.HIin    = 1'b0;
    bus.LOin     = 1'b0;  bus.CONin    = 1'b0;  bus.Gra     = 1'b0;
    bus.Grb      = 1'b0;  bus.Grc      = 1'b0;  bus.IncPC   = 1'b0;
    bus.Read     = 1'b0;  bus.Write    = 1'b0;
    bus.ALUop    = '0;
    bus.Run      = (state != S_HALT);
    unique case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        if (is_ld || is_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (is_r || is_i) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_br) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
        end else if (is_jr) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (is_md) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end
`endif
      end
      S_T4: begin
        if (is_r) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ALUop = alu_op;
        end else if (is_i) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUop = alu_op;
        end else if (is_ld || is_st) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUop = ALU_ADD;
        end else if (is_br) begin
          bus.PCout = 1'b1; bus.Yin = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (is_md) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ALUop = alu_op;
        end
`endif
      end
      S_T5: begin
        if (is_r || is_i) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_ld || is_st) begin
          bus.Zlowout = 1'b1; bus.MARin = 1'b1;
        end else if (is_br) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALUop = ALU_ADD;
        end
`ifdef CTRL_MULDIV_EN
        else if (is_md) begin
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
        end
`endif
      end
      S_T6: begin
        if (is_ld) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
        end else if (is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else if (is_br) begin
          // Branch target is taken only when the condition FF is set.
          bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF;
        end
`ifdef CTRL_MULDIV_EN
        else if (is_md) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end
`endif
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_st) begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions through every
// T-step and compares the full output word (23 strobes, ALUop, Run).
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   total  = 0;
  int   passed = 0;

  control_sequencer_if #(.ALUW(4)) bus ();

  control_sequencer #(.OPW(5), .ALUW(4)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  // Strobe masks, order: PCout Zhighout Zlowout MDRout BAout Cout Rout MARin
  // Zin PCin MDRin IRin Yin Rin HIin LOin CONin Gra Grb Grc IncPC Read Write
  localparam logic [22:0] PCOUT = 23'(1) << 22, ZHI   = 23'(1) << 21,
                          ZLO   = 23'(1) << 20, MDROUT= 23'(1) << 19,
                          BAOUT = 23'(1) << 18, COUT  = 23'(1) << 17,
                          ROUT  = 23'(1) << 16, MARIN = 23'(1) << 15,
                          ZIN   = 23'(1) << 14, PCIN  = 23'(1) << 13,
                          MDRIN = 23'(1) << 12, IRIN  = 23'(1) << 11,
                          YIN   = 23'(1) << 10, RIN   = 23'(1) << 9,
                          HIIN  = 23'(1) << 8,  LOIN  = 23'(1) << 7,
                          CONIN = 23'(1) << 6,  GRA   = 23'(1) << 5,
                          GRB   = 23'(1) << 4,  GRC   = 23'(1) << 3,
                          INCPC = 23'(1) << 2,  READ  = 23'(1) << 1,
                          WRITE = 23'(1);
  localparam logic [22:0] NONE = 23'(0);

  task automatic cmp(input string tag, input logic [22:0] s,
                     input logic [3:0] alu, input logic run);
    logic [27:0] obs, exp;
    exp = {s, alu, run};
    obs = {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.BAout,
           bus.Cout, bus.Rout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin,
           bus.IRin, bus.Yin, bus.Rin, bus.HIin, bus.LOin, bus.CONin,
           bus.Gra, bus.Grb, bus.Grc, bus.IncPC, bus.Read, bus.Write,
           bus.ALUop, bus.Run};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock step, then check the state that edge produced.
  task automatic chk(input string tag, input logic [22:0] s,
                     input logic [3:0] alu, input logic run);
    @(negedge Clock);
    cmp(tag, s, alu, run);
  endtask

  task automatic fetch(input logic [31:0] ir);
    bus.IR = ir;
    chk("T0", PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b1);
    chk("T1", ZLO | PCIN | READ | MDRIN, 4'd0, 1'b1);
    chk("T2", MDROUT | IRIN, 4'd0, 1'b1);
  endtask

  // Called right after a negedge check; leaves the unit in RST with the
  // next rising edge going to T0.
  task automatic do_clear();
    #1 Clear = 1'b1;
    #1 cmp("clear_async", NONE, 4'd0, 1'b1);
    @(negedge Clock);
    cmp("clear_hold", NONE, 4'd0, 1'b1);
    Clear = 1'b0;
  endtask

  initial begin
    bus.IR = 32'h0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;
    #2 Clear = 1'b1;
    #1 cmp("reset", NONE, 4'd0, 1'b1);
    @(negedge Clock);
    Clear = 1'b0;

    // addi R2,R1,-5
    fetch(32'h590FFFFB);
    chk("addi_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("addi_T4", COUT | ZIN, 4'd0, 1'b1);
    chk("addi_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    // add
    fetch(32'h18000000);
    chk("add_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("add_T4", GRC | ROUT | ZIN, 4'd0, 1'b1);
    chk("add_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    // sub
    fetch(32'h20000000);
    chk("sub_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("sub_T4", GRC | ROUT | ZIN, 4'd1, 1'b1);
    chk("sub_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    // or (R-type) and andi (I-type) ALU selects
    fetch(32'h30000000);
    chk("or_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("or_T4", GRC | ROUT | ZIN, 4'd3, 1'b1);
    chk("or_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    fetch(32'h60000000);
    chk("andi_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("andi_T4", COUT | ZIN, 4'd2, 1'b1);
    chk("andi_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    // ld
    fetch(32'h00800010);
    chk("ld_T3", GRB | BAOUT | YIN, 4'd0, 1'b1);
    chk("ld_T4", COUT | ZIN, 4'd0, 1'b1);
    chk("ld_T5", ZLO | MARIN, 4'd0, 1'b1);
    chk("ld_T6", READ | MDRIN, 4'd0, 1'b1);
    chk("ld_T7", MDROUT | GRA | RIN, 4'd0, 1'b1);
    // st
    fetch(32'h10800010);
    chk("st_T3", GRB | BAOUT | YIN, 4'd0, 1'b1);
    chk("st_T4", COUT | ZIN, 4'd0, 1'b1);
    chk("st_T5", ZLO | MARIN, 4'd0, 1'b1);
    chk("st_T6", GRA | ROUT | MDRIN, 4'd0, 1'b1);
    chk("st_T7", WRITE, 4'd0, 1'b1);
    // br, not taken then taken
    for (int t = 0; t < 2; t++) begin
      bus.CON_FF = t[0];
      fetch(32'h90000004);
      chk("br_T3", GRA | ROUT | CONIN, 4'd0, 1'b1);
      chk("br_T4", PCOUT | YIN, 4'd0, 1'b1);
      chk("br_T5", COUT | ZIN, 4'd0, 1'b1);
      chk("br_T6", t[0] ? (ZLO | PCIN) : ZLO, 4'd0, 1'b1);
    end
    bus.CON_FF = 1'b0;
    // jr and an unlisted opcode
    fetch(32'hA0000000);
    chk("jr_T3", GRA | ROUT | PCIN, 4'd0, 1'b1);
    fetch(32'hF8000000);
    chk("nop_T3", NONE, 4'd0, 1'b1);
    // mul: full sequence with the option, nop without it
    fetch(32'h78000000);
`ifdef CTRL_MULDIV_EN
    chk("mul_T3", GRA | ROUT | YIN, 4'd0, 1'b1);
    chk("mul_T4", GRB | ROUT | ZIN, 4'd4, 1'b1);
    chk("mul_T5", ZLO | LOIN, 4'd0, 1'b1);
    chk("mul_T6", ZHI | HIIN, 4'd0, 1'b1);
`else
    chk("mul_nop_T3", NONE, 4'd0, 1'b1);
`endif
    // Stop raised in T4 of an add: T5 still runs, then HALT
    fetch(32'h18000000);
    chk("stop_T3", GRB | ROUT | YIN, 4'd0, 1'b1);
    chk("stop_T4", GRC | ROUT | ZIN, 4'd0, 1'b1);
    bus.Stop = 1'b1;
    chk("stop_T5", ZLO | GRA | RIN, 4'd0, 1'b1);
    chk("stop_halt", NONE, 4'd0, 1'b0);
    bus.Stop = 1'b0;
    chk("stop_halt_hold", NONE, 4'd0, 1'b0);
    do_clear();
    // halt instruction, held for 20 clocks
    fetch(32'hD8000000);
    chk("halt_T3", NONE, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) chk("halt_hold", NONE, 4'd0, 1'b0);
    do_clear();
    // ld interrupted by an asynchronous Clear mid-T6
    fetch(32'h00800010);
    chk("ldc_T3", GRB | BAOUT | YIN, 4'd0, 1'b1);
    chk("ldc_T4", COUT | ZIN, 4'd0, 1'b1);
    chk("ldc_T5", ZLO | MARIN, 4'd0, 1'b1);
    chk("ldc_T6", READ | MDRIN, 4'd0, 1'b1);
    do_clear();
    chk("restart_T0", PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the datapath control strobes one T-step per clock.
- Steps: fetch (T0-T2), decode of IR[31:27], execute (T3-T7), then back to T0.
- Replaces the hand-sequenced strobes that per-instruction benches apply today; connects directly to the datapath control inputs.

Parameters:
- OPW, 5, opcode field width (IR[31:27])
- ALUW, 4, width of the ALUop select output

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Clear  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON_FF  in  1  branch-condition flip-flop from the datapath
- Stop  in  1  external stop request
- PCout, Zhighout, Zlowout, MDRout, BAout, Cout, Rout  out  1 each  bus-drive enables
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, CONin  out  1 each  register load enables
- Gra, Grb, Grc  out  1 each  register-field selects
- IncPC, Read, Write  out  1 each  PC increment; memory read/write
- ALUop  out  ALUW  0=ADD, 1=SUB, 2=AND, 3=OR, 4=MUL, 5=DIV
- Run  out  1  1 while executing, 0 in HALT

Behaviour:
- States: RST, T0-T7, HALT.
- Outputs are Moore only: a function of state and latched opcode, held for the whole state.
- Any strobe or select not listed for a state is 0. ALUop is 0 unless listed.
- Clear=1 (async, any time, including mid-instruction): state=RST, all strobes 0, ALUop=0, Run=1.
- Leaving reset: first rising edge after Clear deasserts moves RST->T0.
- Fetch:
  - T0: PCout MARin IncPC Zin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
  - On the T2->T3 edge the opcode is sampled from IR and held until the next T0.
- R-type (add 00011, sub 00100, and 00101, or 00110):
  - T3: Grb Rout Yin
  - T4: Grc Rout Zin, ALUop=op
  - T5: Zlowout Gra Rin
  - T5->T0. Latency 6 clocks.
- I-type (addi 01011, andi 01100, ori 01101):
  - T3: Grb Rout Yin
  - T4: Cout Zin, ALUop=op
  - T5: Zlowout Gra Rin
  - T5->T0.
- ld 00000:
  - T3: Grb BAout Yin
  - T4: Cout Zin, ALUop=ADD
  - T5: Zlowout MARin
  - T6: Read MDRin
  - T7: MDRout Gra Rin
  - T7->T0. Latency 8 clocks.
- st 00010:
  - T3-T5 as ld
  - T6: Gra Rout MDRin
  - T7: Write
  - T7->T0.
- br 10010:
  - T3: Gra Rout CONin
  - T4: PCout Yin
  - T5: Cout Zin, ALUop=ADD
  - T6: Zlowout; PCin asserted only if CON_FF=1 during T6
  - T6->T0.
- jr 10100: T3: Gra Rout PCin; T3->T0.
- nop 11010 and every unlisted opcode: T3 with no strobes; T3->T0.
- halt 11011: T3->HALT. In HALT all strobes are 0 and Run=0; only Clear exits HALT.
- Stop:
  - Sampled on every edge whose next state would be T0.
  - If Stop=1 the next state is HALT instead of T0, so the current instruction always completes.
  - Stop=1 during fetch or mid-execute has no effect until the instruction ends.
- Clear and Stop on the same edge: Clear wins.

Optional Feature:
- Macro: CTRL_MULDIV_EN
- Defined, mul 01111 / div 10000:
  - T3: Gra Rout Yin
  - T4: Grb Rout Zin, ALUop=4 (mul) or 5 (div)
  - T5: Zlowout LOin
  - T6: Zhighout HIin
  - T6->T0.
- Not defined: HIin and LOin are tied to 0; opcodes 01111 and 10000 decode as nop (T3->T0).

Test Plan:
- Clear pulse, then IR=0x590FFFFB (addi R2,R1,-5) -> T0..T5 in 6 clocks; T4 has Cout=1, Zin=1, ALUop=0; T5 has Zlowout=Gra=Rin=1; next state T0.
- IR=0x18000000 (add) -> T4 has Grc=Rout=Zin=1 and ALUop=0; IR=0x20000000 (sub) -> ALUop=1; every other output 0 in every state.
- ld, IR=0x00800010 -> T6 has Read=MDRin=1; T7 has MDRout=Gra=Rin=1; 8 clocks per instruction. st, IR=0x10800010 -> T7 has Write=1 only.
- br, IR=0x90000004, with CON_FF=0 -> PCin=0 in T6; with CON_FF=1 -> PCin=1 in T6; both return to T0 after T6.
- halt, IR=0xD8000000 -> HALT reached after T3, Run=0, state holds for 20 clocks; Clear -> RST with Run=1, then T0. Stop=1 raised during T4 of an add -> T5 completes, then HALT.
- Clear asserted asynchronously mid-T6 of ld -> all outputs 0 immediately, without waiting for a clock edge. With CTRL_MULDIV_EN defined, IR=0x78000000 (mul) -> T5 has LOin=1, T6 has HIin=1; without the macro it executes as nop.
